// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control block: stage indices and FSM encoding.
package pipe_ctrl_pkg;

    localparam int unsigned NUM_STAGES_DEF = 6;

    localparam int unsigned ST_PC  = 0;
    localparam int unsigned ST_IF  = 1;
    localparam int unsigned ST_ID  = 2;
    localparam int unsigned ST_EX  = 3;
    localparam int unsigned ST_MEM = 4;
    localparam int unsigned ST_WB  = 5;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_FLUSH    = 2'd1,
        S_REDIRECT = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter: holds at all ones instead of wrapping.
module pipe_sat_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count register; clear has priority over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall merge, flush/redirect FSM, stall watchdog, perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES = NUM_STAGES_DEF,
    parameter int unsigned MAX_STALL  = 255,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stallreq,
    input  logic                  excp_req,
    input  logic [31:0]           excp_pc,
    input  logic                  wd_clr,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] bubble,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  redirect_valid,
    output logic [31:0]           redirect_pc,
    output logic                  wd_timeout,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int unsigned RL_W = $clog2(MAX_STALL + 1);

    pipe_state_e           state_q;
    pipe_state_e           state_d;
    logic [NUM_STAGES-1:0] therm;
    logic [NUM_STAGES-1:0] edge_m;
    logic                  stall_en;
    logic                  flush_en;
    logic                  accept;
    logic                  stall_any;
    logic                  wd_set;
    logic [RL_W-1:0]       run_len;

    // Thermometer: stage i holds when any stage at or above i requests a stall.
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_therm
        assign therm[gi] = |stallreq[NUM_STAGES-1:gi];
    end

    // Bubble lands on the first stage above the highest held stage.
    assign edge_m[ST_PC] = 1'b0;
    for (genvar gi = 1; gi < NUM_STAGES; gi++) begin : g_bubble
        assign edge_m[gi] = therm[gi-1] & ~therm[gi];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state enables; exceptions outrank stall requests.
    always_comb begin
        state_d  = state_q;
        stall_en = 1'b0;
        flush_en = 1'b0;
        accept   = 1'b0;
        case (state_q)
            S_RUN: begin
                if (excp_req) begin
                    flush_en = 1'b1;
                    accept   = 1'b1;
                    state_d  = S_FLUSH;
                end else begin
                    stall_en = 1'b1;
                end
            end
            S_FLUSH: begin
                flush_en = 1'b1;
                state_d  = S_REDIRECT;
            end
            S_REDIRECT: begin
                stall_en = 1'b1;
                state_d  = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Combinational controls are forced low while reset is asserted.
    assign stall          = (rst && stall_en) ? therm  : '0;
    assign bubble         = (rst && stall_en) ? edge_m : '0;
    assign flush          = (rst && flush_en) ? '1     : '0;
    assign redirect_valid = (state_q == S_REDIRECT);
    assign stall_any      = |stall;

    // Redirect target captured on exception acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_pc <= '0;
        end else if (accept) begin
            redirect_pc <= excp_pc;
        end
    end

    // The cycle that completes MAX_STALL consecutive stalls raises the flag.
    assign wd_set = stall_any && (run_len >= RL_W'(MAX_STALL - 1));

    // Consecutive-stall run length, saturating at MAX_STALL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_len <= '0;
        end else if (!stall_any || flush_en) begin
            run_len <= '0;
        end else if (run_len != RL_W'(MAX_STALL)) begin
            run_len <= run_len + RL_W'(1);
        end
    end

    // Sticky watchdog flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_timeout <= 1'b0;
        end else if (wd_set) begin
            wd_timeout <= 1'b1;
        end else if (wd_clr) begin
            wd_timeout <= 1'b0;
        end
    end

    pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (stall_any),
        .cnt (stall_cnt)
    );

    pipe_sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (accept),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl with a short watchdog and narrow counters.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  stallreq;
    logic        excp_req;
    logic [31:0] excp_pc;
    logic        wd_clr;
    logic [5:0]  stall;
    logic [5:0]  bubble;
    logic [5:0]  flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        wd_timeout;
    logic [2:0]  stall_cnt;
    logic [2:0]  flush_cnt;

    typedef struct packed {
        logic [5:0]  st;
        logic [5:0]  bu;
        logic [5:0]  fl;
        logic        rv;
        logic [31:0] rpc;
        logic        wd;
        logic [2:0]  sc;
        logic [2:0]  fc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rd_q[$];
    int          checks = 0;
    int          errors = 0;

    pipe_ctrl #(.NUM_STAGES(6), .MAX_STALL(4), .CNT_W(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq       (stallreq),
        .excp_req       (excp_req),
        .excp_pc        (excp_pc),
        .wd_clr         (wd_clr),
        .stall          (stall),
        .bubble         (bubble),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .wd_timeout     (wd_timeout),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // One cycle: drive inputs just after the edge, queue the expected outputs.
    task automatic cyc(input logic [5:0] sr, input logic ex, input logic [31:0] pc,
                       input logic wc, input logic r,
                       input logic [5:0] est, input logic [5:0] ebu, input logic [5:0] efl,
                       input logic erv, input logic [31:0] erpc, input logic ewd,
                       input logic [2:0] esc, input logic [2:0] efc);
        exp_t e;
        @(posedge clk);
        #1;
        stallreq = sr;
        excp_req = ex;
        excp_pc  = pc;
        wd_clr   = wc;
        rst      = r;
        e = '{st: est, bu: ebu, fl: efl, rv: erv, rpc: erpc, wd: ewd, sc: esc, fc: efc};
        exp_q.push_back(e);
    endtask

    // Monitor: compare every presented cycle; redirect pulses pop the target queue.
    initial begin
        exp_t e;
        logic [31:0] p;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall",          32'(stall),          32'(e.st));
                chk("bubble",         32'(bubble),         32'(e.bu));
                chk("flush",          32'(flush),          32'(e.fl));
                chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
                chk("redirect_pc",    redirect_pc,         e.rpc);
                chk("wd_timeout",     32'(wd_timeout),     32'(e.wd));
                chk("stall_cnt",      32'(stall_cnt),      32'(e.sc));
                chk("flush_cnt",      32'(flush_cnt),      32'(e.fc));
            end
            if (redirect_valid === 1'b1) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_redirect at %0t: got pc %h expected no pulse", $time, redirect_pc);
                end else begin
                    p = rd_q.pop_front();
                    chk("redirect_target", redirect_pc, p);
                end
            end
        end
    end

    initial begin
        rst      = 1'b0;
        stallreq = '0;
        excp_req = 1'b0;
        excp_pc  = '0;
        wd_clr   = 1'b0;

        // Reset holds outputs low despite a stall request; then stall merge.
        cyc(6'b000100, 0, 32'h0, 0, 0, 6'b000000, 6'b000000, 6'h00, 0, 32'h0, 0, 3'd0, 3'd0);
        cyc(6'b000100, 0, 32'h0, 0, 1, 6'b000111, 6'b001000, 6'h00, 0, 32'h0, 0, 3'd0, 3'd0);
        cyc(6'b100001, 0, 32'h0, 0, 1, 6'b111111, 6'b000000, 6'h00, 0, 32'h0, 0, 3'd1, 3'd0);
        cyc(6'b000000, 0, 32'h0, 0, 1, 6'b000000, 6'b000000, 6'h00, 0, 32'h0, 0, 3'd2, 3'd0);

        // Exception beats stall; repeats in FLUSH/REDIRECT are dropped.
        rd_q.push_back(32'hBFC00380);
        cyc(6'b000100, 1, 32'hBFC00380, 0, 1, 6'b000000, 6'b000000, 6'h3F, 0, 32'h0,        0, 3'd2, 3'd0);
        cyc(6'b000100, 1, 32'h12345678, 0, 1, 6'b000000, 6'b000000, 6'h3F, 0, 32'hBFC00380, 0, 3'd2, 3'd1);
        cyc(6'b000100, 1, 32'h11111111, 0, 1, 6'b000111, 6'b001000, 6'h00, 1, 32'hBFC00380, 0, 3'd2, 3'd1);
        cyc(6'b000000, 0, 32'h0,        0, 1, 6'b000000, 6'b000000, 6'h00, 0, 32'hBFC00380, 0, 3'd3, 3'd1);

        // Fresh reset, then watchdog with a 6-cycle stall.
        cyc(6'b000000, 0, 32'h0, 0, 0, 6'b000000, 6'b000000, 6'h00, 0, 32'h0, 0, 3'd0, 3'd0);
        cyc(6'b000000, 0, 32'h0, 0, 1, 6'b000000, 6'b000000, 6'h00, 0, 32'h0, 0, 3'd0, 3'd0);
        cyc(6'b001000, 0, 32'h0, 0, 1, 6'b001111, 6'b010000, 6'h00, 0, 32'h0, 0, 3'd0, 3'd0);
        cyc(6'b001000, 0, 32'h0, 0, 1, 6'b001111, 6'b010000, 6'h00, 0, 32'h0, 0, 3'd1, 3'd0);
        cyc(6'b001000, 0, 32'h0, 0, 1, 6'b001111, 6'b010000, 6'h00, 0, 32'h0, 0, 3'd2, 3'd0);
        cyc(6'b001000, 0, 32'h0, 0, 1, 6'b001111, 6'b010000, 6'h00, 0, 32'h0, 0, 3'd3, 3'd0);
        cyc(6'b001000, 0, 32'h0, 0, 1, 6'b001111, 6'b010000, 6'h00, 0, 32'h0, 1, 3'd4, 3'd0);
        cyc(6'b001000, 0, 32'h0, 0, 1, 6'b001111, 6'b010000, 6'h00, 0, 32'h0, 1, 3'd5, 3'd0);
        cyc(6'b000000, 0, 32'h0, 0, 1, 6'b000000, 6'b000000, 6'h00, 0, 32'h0, 1, 3'd6, 3'd0);
        cyc(6'b000000, 0, 32'h0, 1, 1, 6'b000000, 6'b000000, 6'h00, 0, 32'h0, 1, 3'd6, 3'd0);
        cyc(6'b000000, 0, 32'h0, 0, 1, 6'b000000, 6'b000000, 6'h00, 0, 32'h0, 0, 3'd6, 3'd0);

        // Stall counter saturates at 7; timeout set wins over a same-cycle clear.
        cyc(6'b100000, 0, 32'h0, 0, 1, 6'b111111, 6'b000000, 6'h00, 0, 32'h0, 0, 3'd6, 3'd0);
        cyc(6'b100000, 0, 32'h0, 0, 1, 6'b111111, 6'b000000, 6'h00, 0, 32'h0, 0, 3'd7, 3'd0);
        cyc(6'b100000, 0, 32'h0, 0, 1, 6'b111111, 6'b000000, 6'h00, 0, 32'h0, 0, 3'd7, 3'd0);
        cyc(6'b100000, 0, 32'h0, 0, 1, 6'b111111, 6'b000000, 6'h00, 0, 32'h0, 0, 3'd7, 3'd0);
        cyc(6'b100000, 0, 32'h0, 1, 1, 6'b111111, 6'b000000, 6'h00, 0, 32'h0, 1, 3'd7, 3'd0);
        cyc(6'b000000, 0, 32'h0, 1, 1, 6'b000000, 6'b000000, 6'h00, 0, 32'h0, 1, 3'd7, 3'd0);
        cyc(6'b000000, 0, 32'h0, 0, 1, 6'b000000, 6'b000000, 6'h00, 0, 32'h0, 0, 3'd7, 3'd0);

        // Reset during FLUSH cancels the redirect and clears the target.
        cyc(6'b000000, 1, 32'hDEADBEEF, 0, 1, 6'b000000, 6'b000000, 6'h3F, 0, 32'h0, 0, 3'd7, 3'd0);
        cyc(6'b000000, 0, 32'h0,        0, 0, 6'b000000, 6'b000000, 6'h00, 0, 32'h0, 0, 3'd0, 3'd0);
        cyc(6'b000000, 0, 32'h0,        0, 1, 6'b000000, 6'b000000, 6'h00, 0, 32'h0, 0, 3'd0, 3'd0);
        cyc(6'b000000, 0, 32'h0,        0, 1, 6'b000000, 6'b000000, 6'h00, 0, 32'h0, 0, 3'd0, 3'd0);

        // Let the monitor drain, then confirm nothing was left unobserved.
        repeat (3) @(posedge clk);
        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("redirect_queue_drained", 32'(rd_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
